// File: rtl/adc_emulator_pkg.sv
// Shared constants for the serial ADC emulator: source modes, FSM encodings and frame length.
package adc_emu_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [1:0] MODE_CONST  = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_EXT    = 2'd3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_TRAIL = 2'd2;

endpackage

// File: rtl/adc_emulator_if.sv
// Serial ADC link: the receiver (master) drives SCLK/CS, the emulator (slave) drives data and pad enable.
interface adc_emulator_if;

  logic adc_clk;
  logic adc_cs;
  logic adc_sd;
  logic adc_sd_oe;

  modport master (output adc_clk, output adc_cs, input adc_sd, input adc_sd_oe);
  modport slave  (input adc_clk, input adc_cs, output adc_sd, output adc_sd_oe);

endinterface

// File: rtl/adc_emulator_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with registered one-cycle rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_r;

  // Synchronise the pin and compare the two oldest stages to produce edge pulses.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_r <= 3'b000;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[1:0], din};
      rise   <= sync_r[1] & ~sync_r[2];
      fall   <= ~sync_r[1] & sync_r[2];
    end
  end

endmodule

// File: rtl/adc_emulator.sv
// Transmit end of the serial ADC link: shifts 4 leading zeros and a 12-bit sample MSB first
// on SCLK falling edges, with the sample taken from a pattern generator or an external word.
module adc_emulator
  import adc_emu_pkg::*;
#(
  parameter int                      SAMPLE_WIDTH = 12,
  parameter int                      LEAD_ZEROS   = 4,
  parameter int                      PHASE_W      = 16,
  parameter logic [SAMPLE_WIDTH-1:0] CONST_VALUE  = 12'h800
) (
  input  logic                    clk,
  input  logic                    resetn,
  adc_emulator_if.slave           link,
  input  logic [1:0]              mode,
  input  logic [PHASE_W-1:0]      phase_inc,
  input  logic [SAMPLE_WIDTH-1:0] ext_sample,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    frame_done
);

  localparam int FRAME_LEN = LEAD_ZEROS + SAMPLE_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    cs_rise;
  logic                    cs_fall;
  logic [1:0]              state_r;
  logic [FRAME_LEN-1:0]    shreg_r;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [PHASE_W-1:0]      phase_r;
  logic [SAMPLE_WIDTH-1:0] sample_r;
  logic                    sd_r;
  logic                    oe_r;
  logic                    frame_done_r;
  logic [SAMPLE_WIDTH-1:0] next_sample;

  sync_edge u_sclk_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (link.adc_clk),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  sync_edge u_cs_sync (
    .clk    (clk),
    .resetn (resetn),
    .din    (link.adc_cs),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  // Select the word for the next frame from the pre-increment phase.
  always_comb begin
    next_sample = CONST_VALUE;
    case (mode)
      MODE_CONST:  next_sample = CONST_VALUE;
      MODE_SAW:    next_sample = phase_r[PHASE_W-1 -: SAMPLE_WIDTH];
      MODE_SQUARE: begin
        if (phase_r[PHASE_W-1]) begin
          next_sample = {SAMPLE_WIDTH{1'b1}};
        end else begin
          next_sample = {SAMPLE_WIDTH{1'b0}};
        end
      end
      MODE_EXT:    next_sample = ext_sample;
      default:     next_sample = CONST_VALUE;
    endcase
  end

  // Frame FSM: a CS fall always restarts a frame, so it beats a coincident SCLK fall.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      shreg_r      <= {FRAME_LEN{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      phase_r      <= {PHASE_W{1'b0}};
      sample_r     <= {SAMPLE_WIDTH{1'b0}};
      sd_r         <= 1'b0;
      oe_r         <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      if (cs_fall) begin
        sample_r  <= next_sample;
        shreg_r   <= {{LEAD_ZEROS{1'b0}}, next_sample};
        sd_r      <= 1'b0;
        bit_cnt_r <= {CNT_W{1'b0}};
        phase_r   <= phase_r + phase_inc;
        oe_r      <= 1'b1;
        state_r   <= ST_SHIFT;
      end else begin
        case (state_r)
          ST_IDLE: begin
            oe_r <= 1'b0;
            sd_r <= 1'b0;
          end
          ST_SHIFT: begin
            if (cs_rise) begin
              state_r <= ST_IDLE;
              oe_r    <= 1'b0;
              sd_r    <= 1'b0;
            end else if (sclk_fall) begin
              if (bit_cnt_r == CNT_W'(FRAME_LEN - 1)) begin
                sd_r         <= 1'b0;
                frame_done_r <= 1'b1;
                state_r      <= ST_TRAIL;
              end else begin
                shreg_r   <= {shreg_r[FRAME_LEN-2:0], 1'b0};
                sd_r      <= shreg_r[FRAME_LEN-2];
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              end
            end else if (sclk_rise) begin
              // The receiver samples on this edge, so the data bit is held.
              sd_r <= sd_r;
            end else begin
              sd_r <= sd_r;
            end
          end
          ST_TRAIL: begin
            sd_r <= 1'b0;
            if (cs_rise) begin
              state_r <= ST_IDLE;
              oe_r    <= 1'b0;
            end else begin
              oe_r <= 1'b1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            oe_r    <= 1'b0;
            sd_r    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign link.adc_sd    = sd_r;
  assign link.adc_sd_oe = oe_r;
  assign sample         = sample_r;
  assign frame_done     = frame_done_r;

endmodule

// File: tb/tb_adc_emulator.sv
// Receiver-side bench for adc_emulator: drives CS/SCLK, reads bits on SCLK rise, scoreboards frames.
module tb_adc_emulator;
  import adc_emu_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  mode;
  logic [15:0] phase_inc;
  logic [11:0] ext_sample;
  logic [11:0] sample;
  logic        frame_done;

  int          errors = 0;
  int          checks = 0;
  int          fd_cnt = 0;
  logic [15:0] model_phase;
  logic [15:0] exp_q[$];

  adc_emulator_if link();

  adc_emulator dut (
    .clk        (clk),
    .resetn     (resetn),
    .link       (link),
    .mode       (mode),
    .phase_inc  (phase_inc),
    .ext_sample (ext_sample),
    .sample     (sample),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] model_sample();
    case (mode)
      MODE_CONST:  return 12'h800;
      MODE_SAW:    return model_phase[15:4];
      MODE_SQUARE: return model_phase[15] ? 12'hFFF : 12'h000;
      default:     return ext_sample;
    endcase
  endfunction

  // One CS frame with n_sclk SCLK pulses; bits are read just before each SCLK rise.
  task automatic run_frame(input int n_sclk);
    logic [15:0] exp_word;
    logic [15:0] rx;
    int          extra_ones;
    int          fd0;
    int          nb;
    exp_q.push_back({4'h0, model_sample()});
    model_phase = model_phase + phase_inc;
    fd0        = fd_cnt;
    rx         = 16'h0000;
    extra_ones = 0;
    link.adc_cs = 1'b0;
    repeat (8) @(negedge clk);
    check_val("oe_on", {31'd0, link.adc_sd_oe}, 32'd1);
    for (int i = 0; i < n_sclk; i++) begin
      if (i < 16) rx = {rx[14:0], link.adc_sd};
      else extra_ones += int'(link.adc_sd);
      link.adc_clk = 1'b1;
      repeat (4) @(negedge clk);
      link.adc_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    exp_word = exp_q.pop_front();
    nb = (n_sclk < 16) ? n_sclk : 16;
    check_val("bits", {16'd0, rx}, {16'd0, exp_word >> (16 - nb)});
    if (n_sclk > 16) check_val("trail_zero", extra_ones, 32'd0);
    check_val("sample", {20'd0, sample}, {20'd0, exp_word[11:0]});
    check_val("frame_done", fd_cnt - fd0, (n_sclk >= 16) ? 32'd1 : 32'd0);
    link.adc_cs = 1'b1;
    repeat (4) @(negedge clk);
    check_val("oe_off", {31'd0, link.adc_sd_oe}, 32'd0);
    check_val("sd_idle", {31'd0, link.adc_sd}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    resetn       = 1'b0;
    link.adc_cs  = 1'b0;
    link.adc_clk = 1'b0;
    mode         = MODE_CONST;
    phase_inc    = 16'h0000;
    ext_sample   = 12'h000;
    model_phase  = 16'h0000;
    repeat (4) @(negedge clk);
    check_val("rst_sd", {31'd0, link.adc_sd}, 32'd0);
    check_val("rst_oe", {31'd0, link.adc_sd_oe}, 32'd0);
    check_val("rst_sample", {20'd0, sample}, 32'd0);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check_val("cs_low_at_reset", {31'd0, link.adc_sd_oe}, 32'd0);
    link.adc_cs = 1'b1;
    repeat (8) @(negedge clk);

    for (int f = 0; f < 3; f++) run_frame(16);

    mode = MODE_EXT; ext_sample = 12'hA5C;
    run_frame(16);

    mode = MODE_SAW; phase_inc = 16'h1000;
    for (int f = 0; f < 17; f++) run_frame(16);

    mode = MODE_SQUARE; phase_inc = 16'h4000;
    for (int f = 0; f < 8; f++) run_frame(16);

    mode = MODE_CONST; phase_inc = 16'h0100;
    run_frame(7);
    run_frame(16);

    mode = MODE_EXT; ext_sample = 12'h3C9;
    run_frame(20);

    // Reset in the middle of a frame, with CS still low afterwards.
    mode = MODE_SAW; phase_inc = 16'h1000;
    link.adc_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      link.adc_clk = 1'b1;
      repeat (4) @(negedge clk);
      link.adc_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
    check_val("oe_pre_rst", {31'd0, link.adc_sd_oe}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check_val("midrst_oe", {31'd0, link.adc_sd_oe}, 32'd0);
    check_val("midrst_sd", {31'd0, link.adc_sd}, 32'd0);
    resetn = 1'b1;
    model_phase = 16'h0000;
    repeat (10) @(negedge clk);
    check_val("post_rst_idle", {31'd0, link.adc_sd_oe}, 32'd0);
    check_val("post_rst_sample", {20'd0, sample}, 32'd0);
    link.adc_cs = 1'b1;
    repeat (8) @(negedge clk);
    run_frame(16);
    run_frame(16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
